// File: rtl/alu_mw_seq.sv
// Multi-word sequencer: feeds the shared 16-bit ALU one word per cycle, LSW first,
// chains carry/borrow and assembles wide result + flags. Optional: ALUC_SAT_EN.
module alu_mw_seq #(
  parameter int WORDS = 2,
  localparam int W = 16*WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         req_sat,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_res,
  output logic [4:0]   rsp_flg,
  output logic [2:0]   alu_opcode,
  output logic [15:0]  alu_arg1,
  output logic [15:0]  alu_arg2,
  output logic [4:0]   alu_in_flg,
  output logic         alu_block_cy_ov,
  input  logic [15:0]  alu_res,
  input  logic [4:0]   alu_out_flg
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [2:0]   op_q;
  logic [W-1:0] a_q, b_q, res_q;
  logic [1:0]   k_q;
  logic         cy_q;
  logic         last, arith, cy_nxt, cy_fin, ov_fin;
  logic         am, bm, rm;
  logic [15:0]  a_w, b_w;
  logic [W-1:0] res_full, res_fin;
  logic [3:0]   flg_unused;

  assign arith      = (op_q == 3'b000) || (op_q == 3'b001);
  assign last       = (k_q == 2'(WORDS-1));
  assign a_w        = a_q[16*k_q +: 16];
  assign b_w        = b_q[16*k_q +: 16];
  assign am         = a_w[15];
  assign bm         = b_w[15];
  assign rm         = alu_res[15];
  assign rsp_valid  = (state == DONE);
  // Only the ALU carry of word 0 is meaningful; the rest come back as passthrough.
  assign flg_unused = {alu_out_flg[4], alu_out_flg[2:0]};

`ifdef ALUC_SAT_EN
  logic sat_q;
`else
  logic sat_unused;
  assign sat_unused = req_sat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    req_ready       = 1'b0;
    alu_opcode      = 3'b110;
    alu_arg1        = '0;
    alu_arg2        = '0;
    alu_in_flg      = '0;
    alu_block_cy_ov = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = RUN;
      end
      RUN: begin
        alu_opcode = op_q;
        alu_arg1   = a_w;
        alu_arg2   = b_w;
        if (arith && k_q != 2'd0) begin
          alu_block_cy_ov = 1'b1;
          alu_in_flg      = {1'b0, cy_q, 3'b000};
        end
        if (last) state_nxt = DONE;
      end
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cy_nxt = alu_out_flg[3];
    if (k_q != 2'd0)
      cy_nxt = (op_q == 3'b001) ? ((~am & bm) | ((~am | bm) & rm))
                                : ((am & bm) | ((am | bm) & ~rm));
    res_full = res_q;
    res_full[16*k_q +: 16] = alu_res;
    cy_fin = arith & cy_nxt;
    case (op_q)
      3'b000:  ov_fin = (a_q[W-1] == b_q[W-1]) && (res_full[W-1] != a_q[W-1]);
      3'b001:  ov_fin = (a_q[W-1] != b_q[W-1]) && (res_full[W-1] != a_q[W-1]);
      default: ov_fin = 1'b0;
    endcase
    res_fin = res_full;
`ifdef ALUC_SAT_EN
    if (arith && sat_q && ov_fin)
      res_fin = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      cy_q    <= 1'b0;
      rsp_res <= '0;
      rsp_flg <= '0;
`ifdef ALUC_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_q  <= req_op;
          a_q   <= req_a;
          b_q   <= req_b;
          k_q   <= '0;
`ifdef ALUC_SAT_EN
          sat_q <= req_sat;
`endif
        end
        RUN: begin
          res_q <= res_full;
          cy_q  <= cy_nxt;
          k_q   <= k_q + 2'd1;
          if (last) begin
            rsp_res <= res_fin;
            rsp_flg <= {res_fin == '0, cy_fin, res_fin[W-1], ^res_fin, ov_fin};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mw_seq.sv
// Randomized bench for alu_mw_seq with a 16-bit ALU stand-in and a wide-arithmetic reference model.
module tb_alu_mw_seq;
  localparam int WORDS = 2;
  localparam int W = 16*WORDS;
  localparam logic [W-1:0] AND_A = 32'hF0F0F0F0;
  localparam logic [W-1:0] AND_B = 32'hFF00FF00;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid, req_ready, req_sat, rsp_valid, rsp_ready;
  logic [2:0]   req_op, alu_opcode;
  logic [W-1:0] req_a, req_b, rsp_res;
  logic [4:0]   rsp_flg, alu_in_flg, alu_out_flg;
  logic [15:0]  alu_arg1, alu_arg2, alu_res;
  logic         alu_block_cy_ov;
  logic [16:0]  s;
  logic         cin;
  int           n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_mw_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_sat(req_sat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_flg(rsp_flg),
    .alu_opcode(alu_opcode), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2),
    .alu_in_flg(alu_in_flg), .alu_block_cy_ov(alu_block_cy_ov),
    .alu_res(alu_res), .alu_out_flg(alu_out_flg)
  );

  // ALU stand-in: with block_cy_ov it consumes the incoming carry and passes CY through.
  always_comb begin
    cin = alu_block_cy_ov & alu_in_flg[3];
    case (alu_opcode)
      3'b000:  s = {1'b0, alu_arg1} + {1'b0, alu_arg2} + 17'(cin);
      3'b001:  s = {1'b0, alu_arg1} - {1'b0, alu_arg2} - 17'(cin);
      3'b010:  s = {1'b0, alu_arg1 & alu_arg2};
      3'b011:  s = {1'b0, alu_arg1 | alu_arg2};
      3'b100:  s = {1'b0, alu_arg1 ^ alu_arg2};
      3'b101:  s = {1'b0, ~alu_arg1};
      3'b110:  s = {1'b0, alu_arg1};
      default: s = {1'b0, alu_arg2};
    endcase
    alu_res     = s[15:0];
    alu_out_flg = {s[15:0] == 16'd0, alu_block_cy_ov ? alu_in_flg[3] : s[16], s[15], ^s[15:0], 1'b0};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [W-1:0] a, b, input logic sat,
                       output logic [W-1:0] res, output logic [4:0] flg);
    logic [W:0] u, sx;
    logic cy, ov;
    logic sat_unused;
    cy = 1'b0; ov = 1'b0; u = '0; sx = '0;
    sat_unused = sat;
    case (op)
      3'd0: begin u = {1'b0,a} + {1'b0,b}; sx = {a[W-1],a} + {b[W-1],b}; end
      3'd1: begin u = {1'b0,a} - {1'b0,b}; sx = {a[W-1],a} - {b[W-1],b}; end
      3'd2: u = {1'b0, a & b};
      3'd3: u = {1'b0, a | b};
      3'd4: u = {1'b0, a ^ b};
      3'd5: u = {1'b0, ~a};
      3'd6: u = {1'b0, a};
      default: u = {1'b0, b};
    endcase
    res = u[W-1:0];
    if (op <= 3'd1) begin
      cy = u[W];
      ov = sx[W] != sx[W-1];
    end
`ifdef ALUC_SAT_EN
    // clamp toward the sign of the exact result
    if (op <= 3'd1 && sat && ov) res = sx[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    flg = {res == '0, cy, res[W-1], ^res, ov};
  endtask

  // carry/borrow into word k of the exact wide operation
  function automatic logic carry_in(input logic [2:0] op, input logic [W-1:0] a, b, input int k);
    logic [63:0] m, al, bl;
    if (k == 0) return 1'b0;
    m  = (64'd1 << (16*k)) - 64'd1;
    al = 64'(a) & m;
    bl = 64'(b) & m;
    if (op == 3'd0) return ((al + bl) >> (16*k)) != 64'd0;
    return al < bl;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = '1;
      2: r = {1'b1, {(W-1){1'b0}}};
      3: r = {1'b0, {(W-1){1'b1}}};
      default: for (int i = 0; i < WORDS; i++) r[16*i +: 16] = 16'($urandom);
    endcase
    return r;
  endfunction

  task automatic chk_rst();
    chk("rst_ctl", {req_ready, rsp_valid, alu_opcode, alu_block_cy_ov, alu_in_flg},
                   {1'b1, 1'b0, 3'b110, 1'b0, 5'd0});
    chk("rst_args", {alu_arg1, alu_arg2}, 64'd0);
    chk("rst_rsp", {rsp_flg, rsp_res}, 64'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b, input logic sat, output int waits);
    waits = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_sat = sat;
    while (!req_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) chk("accept_timeout", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_a = rnd(); req_b = rnd(); req_sat = 1'($urandom);
  endtask

  task automatic finish_op(input logic [2:0] op, input logic [W-1:0] a, b, input logic sat,
                           input int hold, input logic nxt,
                           output logic [W-1:0] got_res, output logic [4:0] got_flg);
    logic [W-1:0] er;
    logic [4:0]   ef;
    logic         blk;
    logic [40:0]  ew;
    int lat, k;
    lat = 1; k = 0;
    model(op, a, b, sat, er, ef);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      blk = (op <= 3'd1) && (k > 0);
      ew  = {op, a[16*k +: 16], b[16*k +: 16], blk,
             blk ? {1'b0, carry_in(op, a, b, k), 3'b000} : 5'd0};
      chk("alu_word", {alu_opcode, alu_arg1, alu_arg2, alu_block_cy_ov, alu_in_flg}, ew);
      k++;
      @(posedge clk);
      lat++;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("latency", 64'(lat), 64'(WORDS + 1));
    chk("rsp_res", rsp_res, er);
    chk("rsp_flg", rsp_flg, ef);
    got_res = rsp_res;
    got_flg = rsp_flg;
    if (nxt) begin
      req_valid = 1'b1; req_op = 3'd2; req_a = AND_A; req_b = AND_B; req_sat = 1'b0;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_ctl", {rsp_valid, req_ready, rsp_flg}, {1'b1, 1'b0, ef});
      chk("hold_res", rsp_res, er);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
    chk("rsp_keep", {rsp_flg, rsp_res}, {ef, er});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] r, ra, rb;
    logic [4:0]   f;
    logic [2:0]   rop;
    logic         rs;
    int           w;
    req_valid = 0; req_op = 0; req_a = 0; req_b = 0; req_sat = 0; rsp_ready = 0;
    #12;
    chk_rst();
    @(negedge clk);
    rst_n = 1'b1;

    issue(3'd0, 32'h0000FFFF, 32'h00000001, 1'b0, w);
    finish_op(3'd0, 32'h0000FFFF, 32'h00000001, 1'b0, 0, 1'b0, r, f);
    chk("add_carry", {f, r}, {5'b00010, 32'h00010000});

    issue(3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0, w);
    finish_op(3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, r, f);
    chk("add_wrap", {f, r}, {5'b11000, 32'h00000000});

    issue(3'd1, 32'h80000000, 32'h00000001, 1'b1, w);
    finish_op(3'd1, 32'h80000000, 32'h00000001, 1'b1, 0, 1'b0, r, f);
`ifdef ALUC_SAT_EN
    chk("sub_ovf", {f, r}, {5'b00111, 32'h80000000});
`else
    chk("sub_ovf", {f, r}, {5'b00011, 32'h7FFFFFFF});
`endif

    issue(3'd1, 32'h00000000, 32'h00000001, 1'b0, w);
    finish_op(3'd1, 32'h00000000, 32'h00000001, 1'b0, 0, 1'b0, r, f);
    chk("sub_borrow", {f, r}, {5'b01100, 32'hFFFFFFFF});

    issue(3'd4, 32'h1234ABCD, 32'h1234ABCD, 1'b0, w);
    finish_op(3'd4, 32'h1234ABCD, 32'h1234ABCD, 1'b0, 0, 1'b0, r, f);
    chk("xor_zero", {f, r}, {5'b10000, 32'h00000000});

    // stall in DONE with the next request already waiting
    ra = rnd(); rb = rnd();
    issue(3'd0, ra, rb, 1'b0, w);
    finish_op(3'd0, ra, rb, 1'b0, 5, 1'b1, r, f);
    issue(3'd2, AND_A, AND_B, 1'b0, w);
    chk("b2b_wait", 64'(w), 64'd0);
    finish_op(3'd2, AND_A, AND_B, 1'b0, 0, 1'b0, r, f);
    chk("and_res", {f, r}, {5'b00100, 32'hF000F000});

    // reset while the second word is on the ALU
    ra = rnd(); rb = rnd();
    issue(3'd0, ra, rb, 1'b0, w);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_rst();
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd0, 32'd1, 32'd2, 1'b0, w);
    finish_op(3'd0, 32'd1, 32'd2, 1'b0, 0, 1'b0, r, f);
    chk("post_rst_add", r, 32'h00000003);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom); ra = rnd(); rb = rnd(); rs = 1'($urandom);
      issue(rop, ra, rb, rs, w);
      finish_op(rop, ra, rb, rs, int'($urandom_range(0, 2)), 1'b0, r, f);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
